mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width; the legal values are 32 and 64.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 flush  input  1  synchronous abort of any operation in flight.
REQ-005 in_valid  input  1  a request is presented.
REQ-006 in_ready  output  1  the block accepts a request this cycle.
REQ-007 in_op  input  3  operation code: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-008 in_word  input  1  RV64 W-form select; the port SHALL be present only when the Configuration macro is defined.
REQ-009 in_src1 / in_src2  input  XLEN  operands rs1 and rs2.
REQ-010 out_valid  output  1  a result is held.
REQ-011 out_ready  input  1  the consumer takes the result.
REQ-012 out_data  output  XLEN  the result.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL equal (state==IDLE) && !flush.
REQ-016 A handshake (in_valid && in_ready) SHALL latch in_op, in_word and both operands, and move the FSM to CALC.
- Exception: a special divide case moves the FSM directly to DONE.
REQ-017 Multiply SHALL use unsigned shift-add on operand magnitudes, one bit per cycle, over N iterations.
- N = XLEN, or 32 for word ops.
- The 2N-bit product SHALL be negated at the end when the signs differ.
- Signedness: mulh treats both operands as signed; mulhsu treats rs1 as signed and rs2 as unsigned; mulhu treats both as unsigned.
REQ-018 Divide SHALL use radix-2 restoring division on magnitudes over N iterations.
- Quotient sign = sign(rs1) XOR sign(rs2).
- Remainder sign = sign(rs1).
REQ-019 An iteration counter SHALL count from 0 to N-1; the FSM SHALL move CALC -> DONE on the edge where the counter equals N-1.
REQ-020 Latency for a normal operation SHALL be N+1 cycles.
- Accept on edge k gives out_valid high after edge k+N+1.
- N+1 = 65 for XLEN=64; 33 for word ops or XLEN=32.
REQ-021 Divide by zero SHALL skip CALC and reach DONE on the edge after acceptance.
- div and divu return all ones.
- rem and remu return rs1.
REQ-022 Signed overflow (rs1 = most-negative value, rs2 = -1) SHALL skip CALC and reach DONE on the edge after acceptance.
- div returns rs1.
- rem returns 0.
REQ-023 Result selection SHALL be: mul takes the low N bits of the product; mulh, mulhsu and mulhu take the high N bits; div and divu take the quotient; rem and remu take the remainder.
REQ-024 In DONE, out_valid SHALL be high and out_data held stable until out_ready is sampled high; the FSM SHALL then return to IDLE.
REQ-025 out_data SHALL be zero whenever out_valid is low.
REQ-026 flush in any state SHALL force IDLE on the next edge and discard the result.
- flush in DONE SHALL drop out_valid even if out_ready is high in the same cycle.
REQ-027 Simultaneous flush and in_valid SHALL not accept the request, because in_ready is low.
REQ-028 Throughput SHALL be one operation in flight; a new request is accepted no earlier than the cycle after the DONE -> IDLE transition.

Reset
REQ-029 On rst_n low the block SHALL asynchronously enter IDLE and clear the counter, operand, accumulator and result registers.
REQ-030 During reset the outputs SHALL be out_valid=0, out_data=0 and busy=0; in_ready SHALL be 1 once flush is low.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abandon the operation with no result produced.

Configuration
REQ-032 Macro MDU_RV64W_EN, when defined and XLEN=64, SHALL add the in_word port.
- in_word=1 operates on src[31:0] with N=32.
- The 32-bit result SHALL be sign-extended to 64 bits; this applies to divuw and remuw too.
- in_word=1 with mulh, mulhsu or mulhu SHALL be treated as mul (mulw).
REQ-033 Without MDU_RV64W_EN, the in_word port SHALL be absent and all operations SHALL be full-XLEN.

Verification
REQ-034 mul, XLEN=64: src1=7, src2=-3 -> out_data=0xFFFFFFFFFFFFFFEB, out_valid at cycle 65.
REQ-035 mulhu, XLEN=64: src1=src2=0xFFFFFFFFFFFFFFFF -> out_data=0xFFFFFFFFFFFFFFFE.
REQ-036 Divide by zero, XLEN=64, src1=0x1234, src2=0:
- div -> out_data all ones, out_valid at cycle 2.
- remu -> out_data=0x1234.
REQ-037 Overflow: div with src1=0x8000000000000000, src2=-1 -> out_data=0x8000000000000000; rem with the same operands -> out_data=0.
REQ-038 With MDU_RV64W_EN: divuw with src1=0x80000000, src2=1 -> out_data=0xFFFFFFFF80000000, latency 33.
REQ-039 Backpressure and flush:
- Holding out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0.
- flush at cycle 20 of CALC -> IDLE next cycle, no out_valid.
- rst_n pulse mid-CALC -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional RV64 W-form support (in_word port) is enabled by defining MDU_RV64W_EN.
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
`ifdef MDU_RV64W_EN
  input  logic            in_word,
`endif
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              word_q;
  logic              prep;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   src1_q, src2_q, opa;
  logic [2*XLEN-1:0] acc;
  logic              neg1_q, neg2_q;

  logic              word_sel;
`ifdef MDU_RV64W_EN
  assign word_sel = in_word && (XLEN == 64);
`else
  assign word_sel = 1'b0;
`endif

  // W-form high-half multiplies collapse to mulw
  logic [2:0] op_eff;
  assign op_eff = (word_sel && (in_op inside {3'd1, 3'd2, 3'd3})) ? 3'd0 : in_op;

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);

  logic [XLEN-1:0] s1_in, spec_res;
  logic            div_zero, div_ovf;
  assign s1_in    = word_sel ? XLEN'($signed(in_src1[31:0])) : in_src1;
  assign div_zero = word_sel ? (in_src2[31:0] == 32'd0) : (in_src2 == '0);
  assign div_ovf  = op_eff[2] && !op_eff[0] &&
                    (word_sel ? (in_src1[31:0] == 32'h8000_0000 && &in_src2[31:0])
                              : (in_src1 == {1'b1, {(XLEN-1){1'b0}}} && &in_src2));

  always_comb begin
    spec_res = '1;
    if (div_zero) spec_res = op_eff[1] ? s1_in : '1;
    else          spec_res = op_eff[1] ? '0 : s1_in;
  end

  // mul runs unsigned: the low half of a product does not depend on operand signedness
  logic            signed1, signed2, neg1, neg2;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2;
  always_comb begin
    signed1 = op_q inside {3'd1, 3'd2, 3'd4, 3'd6};
    signed2 = op_q inside {3'd1, 3'd4, 3'd6};
    if (word_q) begin
      ext1 = signed1 ? XLEN'($signed(src1_q[31:0])) : XLEN'(src1_q[31:0]);
      ext2 = signed2 ? XLEN'($signed(src2_q[31:0])) : XLEN'(src2_q[31:0]);
    end else begin
      ext1 = src1_q;
      ext2 = src2_q;
    end
    neg1 = signed1 && ext1[XLEN-1];
    neg2 = signed2 && ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, quo_res, rem_res, res;
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opa};
    if (!op_q[2]) acc_step = {mul_sum, acc[XLEN-1:1]};
    else          acc_step = {div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0],
                              acc[XLEN-2:0], ~div_diff[XLEN]};
    prod    = (neg1_q ^ neg2_q) ? -acc_step : acc_step;
    quo     = acc_step[XLEN-1:0];
    rem     = acc_step[2*XLEN-1:XLEN];
    quo_res = (neg1_q ^ neg2_q) ? -quo : quo;
    rem_res = neg1_q ? -rem : rem;
    case (op_q)
      3'd0:          res = word_q ? XLEN'($signed(acc_step[XLEN-1 -: 32])) : prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:    res = quo_res;
      default:       res = rem_res;
    endcase
    if (word_q && op_q[2]) res = XLEN'($signed(res[31:0]));
  end

  logic [CW-1:0] last;
  assign last = word_q ? CW'(31) : CW'(XLEN-1);

  // The first CALC cycle only loads magnitudes; the counter then covers N iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      prep      <= 1'b0;
      cnt       <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      opa       <= '0;
      acc       <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      prep      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= op_eff;
          word_q <= word_sel;
          src1_q <= in_src1;
          src2_q <= in_src2;
          cnt    <= '0;
          if (op_eff[2] && (div_zero || div_ovf)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= spec_res;
          end else begin
            state <= CALC;
            prep  <= 1'b1;
          end
        end
        CALC: if (prep) begin
          prep   <= 1'b0;
          neg1_q <= neg1;
          neg2_q <= neg2;
          opa    <= op_q[2] ? mag2 : mag1;
          acc    <= op_q[2] ? {{XLEN{1'b0}}, (word_q ? (mag1 << (XLEN-32)) : mag1)}
                            : {{XLEN{1'b0}}, mag2};
        end else begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= res;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed table-driven bench for mdu_iter (XLEN=64); W-form vectors run only when MDU_RV64W_EN is defined.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1, in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
`ifdef MDU_RV64W_EN
    .in_word(in_word),
`endif
    .in_src1(in_src1),
    .in_src2(in_src2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issues one request, waits for the result and returns data plus edges from accept to out_valid.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                               input logic word, output logic [63:0] data, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = s1;
    in_src2  = s2;
    in_word  = word;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    data = out_data;
  endtask

  task automatic takeResult(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, " valid after take"}, {63'd0, out_valid}, 64'd0);
    checkOutput({name, " data after take"}, out_data, 64'd0);
  endtask

  task automatic waitNoResult(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput({name, " no result"}, {63'd0, seen}, 64'd0);
    checkOutput({name, " idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] data, held;
    int          lat;
    logic        stable;

    vecs[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'd4, 64'h1234, 64'd0, ONES, 1};
    vecs[3]  = '{3'd7, 64'h1234, 64'd0, 64'h1234, 1};
    vecs[4]  = '{3'd4, MINV, ONES, MINV, 1};
    vecs[5]  = '{3'd6, MINV, ONES, 64'd0, 1};
    vecs[6]  = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 65};
    vecs[7]  = '{3'd2, ONES, ONES, ONES, 65};
    vecs[8]  = '{3'd1, ONES, ONES, 64'd0, 65};
    vecs[9]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[10] = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65};
    vecs[11] = '{3'd5, 64'd100, 64'd7, 64'd14, 65};
    vecs[12] = '{3'd7, 64'd100, 64'd7, 64'd2, 65};
    vecs[13] = '{3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    vecs[14] = '{3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[15] = '{3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 65};
    vecs[16] = '{3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 65};
    vecs[17] = '{3'd5, ONES, 64'd1, ONES, 65};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
    in_word = 1'b0; in_src1 = '0; in_src2 = '0; out_ready = 1'b0;
    #2;
    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset out_data", out_data, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].s1, vecs[i].s2, 1'b0, data, lat);
      checkOutput($sformatf("vec%0d data", i), data, vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      takeResult($sformatf("vec%0d", i));
    end

`ifdef MDU_RV64W_EN
    applyStimulus(3'd5, 64'h8000_0000, 64'd1, 1'b1, data, lat);
    checkOutput("divuw data", data, 64'hFFFF_FFFF_8000_0000);
    checkOutput("divuw latency", 64'(lat), 64'd33);
    takeResult("divuw");
    applyStimulus(3'd1, 64'hFFFF_FFFF, 64'd3, 1'b1, data, lat);
    checkOutput("mulw data", data, 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("mulw latency", 64'(lat), 64'd33);
    takeResult("mulw");
`endif

    // Backpressure: result must hold while a competing request is presented
    applyStimulus(3'd0, 64'd6, 64'd7, 1'b0, held, lat);
    checkOutput("bp data", held, 64'd42);
    stable = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_src1 = 64'd9; in_src2 = 64'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_data !== held || !out_valid || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("bp held stable", {63'd0, stable}, 64'd1);
    takeResult("bp");

    // Flush in CALC, together with a request that must not be taken
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd3; in_src2 = 64'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    checkOutput("flush in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("flush calc busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    waitNoResult("flush calc", 80);

    // Flush in DONE wins over a simultaneous out_ready
    applyStimulus(3'd4, 64'h55, 64'd0, 1'b0, data, lat);
    checkOutput("fdone data", data, ONES);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("fdone valid", {63'd0, out_valid}, 64'd0);
    checkOutput("fdone data cleared", out_data, 64'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    waitNoResult("fdone", 5);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_src1 = 64'd1000; in_src2 = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid busy", {63'd0, busy}, 64'd0);
    checkOutput("rst mid out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst mid out_data", out_data, 64'd0);
    checkOutput("rst mid in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    waitNoResult("rst mid", 80);

    applyStimulus(3'd5, 64'd1000, 64'd3, 1'b0, data, lat);
    checkOutput("post rst data", data, 64'd333);
    checkOutput("post rst latency", 64'(lat), 64'd65);
    takeResult("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
